// File: rtl/deadlock_monitor_pkg.sv
// Shared types and constants for the parametrised deadlock monitor.
// Optional peak-stall tracking is enabled by DEADLOCK_MONITOR_PEAK_EN (see top).
package deadlock_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DEADLOCK = 2'd2
    } dlm_state_e;

    localparam int DLM_DEFAULT_TIMEOUT = 1024;

    // Index width for an N-entry vector; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dlm_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module dlm_prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan from the top bit down so the lowest set bit is written last and wins.
    always_comb begin
        idx_o   = '0;
        valid_o = |vec_i;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec_i[N-1-i]) begin
                idx_o = W'(N - 1 - i);
            end
        end
    end

endmodule

// File: rtl/deadlock_monitor_param.sv
// Deadlock monitor for HLS dataflow kernels: declares deadlock after the
// "all instances idle-or-blocked, some blocked, no AXIS stall" condition
// holds for TIMEOUT consecutive cycles, then holds a diagnostic snapshot
// until cleared.
// Optional: define DEADLOCK_MONITOR_PEAK_EN to add the max_stall output.
module deadlock_monitor_param
    import deadlock_monitor_pkg::*;
#(
    parameter int N_INST  = 6,
    parameter int N_AXIS  = 2,
    parameter int TIMEOUT = DLM_DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = clog2_min1(N_INST)
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_pulse,
    output logic [N_INST-1:0] blocked_mask,
    output logic [IDX_W-1:0]  first_blk_idx,
    output logic [CNT_W-1:0]  stall_cycles
`ifdef DEADLOCK_MONITOR_PEAK_EN
    ,
    output logic [CNT_W-1:0]  max_stall
`endif
);

    localparam logic [CNT_W-1:0] THRESH     = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
    localparam bit               DIRECT_HIT = (TIMEOUT == 1);

    dlm_state_e        state_q;
    logic              block_q;
    logic              pulse_q;
    logic [N_INST-1:0] mask_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  stall_q;

    logic              cand_d;
    logic              detect_d;
    logic [CNT_W-1:0]  stall_inc_d;
    logic [IDX_W-1:0]  prio_idx;
    logic              prio_valid;

    dlm_prio_enc #(
        .N (N_INST),
        .W (IDX_W)
    ) u_prio (
        .vec_i   (inst_block_sigs),
        .idx_o   (prio_idx),
        .valid_o (prio_valid)
    );

    // Candidate condition, threshold hit and saturating counter increment.
    always_comb begin
        cand_d      = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs)
                      & ~(|axis_block_sigs);
        stall_inc_d = (stall_q == '1) ? stall_q : stall_q + CNT_W'(1);
        detect_d    = 1'b0;
        if (cand_d && prio_valid) begin
            if (state_q == IDLE && DIRECT_HIT) begin
                detect_d = 1'b1;
            end else if (state_q == WATCH && stall_q == THRESH) begin
                detect_d = 1'b1;
            end
        end
    end

    // Monitor FSM with registered snapshot outputs; reset dominates clear.
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            state_q <= IDLE;
            block_q <= 1'b0;
            pulse_q <= 1'b0;
            mask_q  <= '0;
            idx_q   <= '0;
            stall_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (detect_d) begin
                // TIMEOUT==1 reaches here straight from IDLE with identical captures.
                state_q <= DEADLOCK;
                block_q <= 1'b1;
                pulse_q <= 1'b1;
                mask_q  <= inst_block_sigs;
                idx_q   <= prio_idx;
                stall_q <= TIMEOUT_V;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cand_d) begin
                            state_q <= WATCH;
                            stall_q <= CNT_W'(1);
                        end else begin
                            stall_q <= '0;
                        end
                    end
                    WATCH: begin
                        if (!cand_d) begin
                            state_q <= IDLE;
                            stall_q <= '0;
                        end else begin
                            stall_q <= stall_inc_d;
                        end
                    end
                    DEADLOCK: begin
                        if (clear) begin
                            state_q <= IDLE;
                            block_q <= 1'b0;
                            mask_q  <= '0;
                            idx_q   <= '0;
                            stall_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        stall_q <= '0;
                    end
                endcase
            end
        end
    end

    assign block         = block_q;
    assign block_pulse   = pulse_q;
    assign blocked_mask  = mask_q;
    assign first_blk_idx = idx_q;
    assign stall_cycles  = stall_q;

`ifdef DEADLOCK_MONITOR_PEAK_EN
    logic [CNT_W-1:0] max_q;

    // Peak stall tracker, lags stall_cycles by one cycle; only reset clears it.
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            max_q <= '0;
        end else if (stall_q > max_q) begin
            max_q <= stall_q;
        end
    end

    assign max_stall = max_q;
`endif

endmodule

// File: tb/tb_deadlock_monitor_param.sv
// Bench for deadlock_monitor_param: two instances (TIMEOUT=8 and TIMEOUT=1)
// share one stimulus stream and are checked every cycle against a run-length
// model, plus literal checkpoints.
module tb_deadlock_monitor_param;

    logic       clk;
    logic       rst_s;
    logic [1:0] axis_s;
    logic [5:0] idle_s;
    logic [5:0] blk_s;
    logic       clr_s;

    logic [1:0]  o_block;
    logic [1:0]  o_pulse;
    logic [5:0]  o_mask  [2];
    logic [2:0]  o_idx   [2];
    logic [15:0] o_stall [2];
    logic [15:0] o_peak  [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Model state: consecutive-candidate run length and deadlock snapshot.
    int       m_run   [2];
    bit       m_dead  [2];
    bit       m_pulse [2];
    int       m_mask  [2];
    int       m_idx   [2];
    int       m_peak  [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    deadlock_monitor_param #(
        .N_INST(6), .N_AXIS(2), .TIMEOUT(8), .CNT_W(16)
    ) dut0 (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst_s),
        .axis_block_sigs(axis_s),
        .inst_idle_sigs(idle_s),
        .inst_block_sigs(blk_s),
        .clear(clr_s),
        .block(o_block[0]),
        .block_pulse(o_pulse[0]),
        .blocked_mask(o_mask[0]),
        .first_blk_idx(o_idx[0]),
        .stall_cycles(o_stall[0])
`ifdef DEADLOCK_MONITOR_PEAK_EN
        ,
        .max_stall(o_peak[0])
`endif
    );

    deadlock_monitor_param #(
        .N_INST(6), .N_AXIS(2), .TIMEOUT(1), .CNT_W(16)
    ) dut1 (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst_s),
        .axis_block_sigs(axis_s),
        .inst_idle_sigs(idle_s),
        .inst_block_sigs(blk_s),
        .clear(clr_s),
        .block(o_block[1]),
        .block_pulse(o_pulse[1]),
        .blocked_mask(o_mask[1]),
        .first_blk_idx(o_idx[1]),
        .stall_cycles(o_stall[1])
`ifdef DEADLOCK_MONITOR_PEAK_EN
        ,
        .max_stall(o_peak[1])
`endif
    );

`ifndef DEADLOCK_MONITOR_PEAK_EN
    initial begin
        o_peak[0] = '0;
        o_peak[1] = '0;
    end
`endif

    function automatic int lowest_bit(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts consecutive candidate cycles per instance.
    always @(posedge clk) begin
        bit cand;
        int to;
        cand = (&(idle_s | blk_s)) && (|blk_s) && !(|axis_s);
        for (int k = 0; k < 2; k++) begin
            to = (k == 0) ? 8 : 1;
            if (rst_s) begin
                m_peak[k] = 0;
            end else if (m_run[k] > m_peak[k]) begin
                m_peak[k] = m_run[k];
            end
            m_pulse[k] = 0;
            if (rst_s) begin
                m_run[k]  = 0;
                m_dead[k] = 0;
                m_mask[k] = 0;
                m_idx[k]  = 0;
            end else if (m_dead[k]) begin
                if (clr_s) begin
                    m_dead[k] = 0;
                    m_run[k]  = 0;
                    m_mask[k] = 0;
                    m_idx[k]  = 0;
                end
            end else if (cand) begin
                if (m_run[k] < 65535) m_run[k] = m_run[k] + 1;
                if (m_run[k] == to) begin
                    m_dead[k]  = 1;
                    m_pulse[k] = 1;
                    m_mask[k]  = int'(blk_s);
                    m_idx[k]   = lowest_bit(blk_s);
                end
            end else begin
                m_run[k] = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("block[%0d]", k), 32'(o_block[k]), 32'(m_dead[k]));
                check($sformatf("pulse[%0d]", k), 32'(o_pulse[k]), 32'(m_pulse[k]));
                check($sformatf("mask[%0d]", k),  32'(o_mask[k]),  32'(m_mask[k]));
                check($sformatf("idx[%0d]", k),   32'(o_idx[k]),   32'(m_idx[k]));
                check($sformatf("stall[%0d]", k), 32'(o_stall[k]), 32'(m_run[k]));
`ifdef DEADLOCK_MONITOR_PEAK_EN
                check($sformatf("peak[%0d]", k),  32'(o_peak[k]),  32'(m_peak[k]));
`endif
            end
        end
    end

    task automatic cyc(input logic [5:0] idl, input logic [5:0] bk,
                       input logic [1:0] ax, input logic clr, input logic rst);
        idle_s = idl;
        blk_s  = bk;
        axis_s = ax;
        clr_s  = clr;
        rst_s  = rst;
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] I_A = 6'b111100, B_A = 6'b000011;
    localparam logic [5:0] I_B = 6'b010111, B_B = 6'b101000;
    localparam logic [5:0] ALL = 6'b111111, NONE = 6'b000000;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_dead[k] = 0; m_pulse[k] = 0;
            m_mask[k] = 0; m_idx[k] = 0; m_peak[k] = 0;
        end
        idle_s = ALL; blk_s = NONE; axis_s = 2'b00; clr_s = 1'b0; rst_s = 1'b1;
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b1);
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b1);
        chk_en = 1;
        check("rst_block", 32'(o_block[0]), 0);
        check("rst_stall", 32'(o_stall[0]), 0);
        check("rst_mask",  32'(o_mask[0]),  0);

        // Basic detection at the 8th candidate edge.
        for (int i = 0; i < 7; i++) cyc(I_A, B_A, 2'b00, 1'b0, 1'b0);
        check("t1_stall7", 32'(o_stall[0]), 7);
        check("t1_noblk7", 32'(o_block[0]), 0);
        check("t1_dut1_blk", 32'(o_block[1]), 1);
        cyc(I_A, B_A, 2'b00, 1'b0, 1'b0);
        check("t1_block", 32'(o_block[0]), 1);
        check("t1_pulse", 32'(o_pulse[0]), 1);
        check("t1_mask",  32'(o_mask[0]),  3);
        check("t1_idx",   32'(o_idx[0]),   0);
        check("t1_stall", 32'(o_stall[0]), 8);
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b0);
        check("t1_pulse_drop", 32'(o_pulse[0]), 0);
        check("t1_sticky",     32'(o_block[0]), 1);
        cyc(ALL, NONE, 2'b00, 1'b1, 1'b0);
        check("t1_clr_block", 32'(o_block[0]), 0);
        check("t1_clr_mask",  32'(o_mask[0]),  0);

        // External AXIS stall aborts the watch.
        for (int i = 0; i < 4; i++) cyc(I_A, B_A, 2'b00, 1'b0, 1'b0);
        check("t2_stall4", 32'(o_stall[0]), 4);
        cyc(I_A, B_A, 2'b01, 1'b0, 1'b0);
        check("t2_axis_stall", 32'(o_stall[0]), 0);
        check("t2_axis_block", 32'(o_block[0]), 0);
        cyc(I_A, B_A, 2'b00, 1'b0, 1'b0);
        check("t2_restart", 32'(o_stall[0]), 1);
        cyc(ALL, NONE, 2'b00, 1'b1, 1'b0);

        // Kernel finished: all idle, nothing blocked.
        for (int i = 0; i < 100; i++) cyc(ALL, NONE, 2'b00, 1'b0, 1'b0);
        check("t3_stall", 32'(o_stall[0]), 0);
        check("t3_block", 32'(o_block[0]), 0);

        // Frozen snapshot, then clear and re-detect.
        for (int i = 0; i < 8; i++) cyc(I_B, B_B, 2'b00, 1'b0, 1'b0);
        check("t4_block", 32'(o_block[0]), 1);
        check("t4_idx",   32'(o_idx[0]),   3);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a, b;
            a = 32'(i * 7);
            b = 32'(i * 13 + 1);
            cyc(a[5:0], b[5:0], a[1:0], 1'b0, 1'b0);
        end
        check("t4_frozen_mask",  32'(o_mask[0]),  32'h28);
        check("t4_frozen_stall", 32'(o_stall[0]), 8);
        cyc(ALL, NONE, 2'b00, 1'b1, 1'b0);
        check("t4_clr_block", 32'(o_block[0]), 0);
        check("t4_clr_mask",  32'(o_mask[0]),  0);
        for (int i = 0; i < 7; i++) cyc(I_B, B_B, 2'b00, 1'b0, 1'b0);
        check("t4_redet7", 32'(o_block[0]), 0);
        cyc(I_B, B_B, 2'b00, 1'b0, 1'b0);
        check("t4_redet8", 32'(o_block[0]), 1);

        // Reset with clear mid-watch; then TIMEOUT=1 single-cycle detection.
        cyc(ALL, NONE, 2'b00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(I_B, B_B, 2'b00, 1'b0, 1'b0);
        check("t5_stall5", 32'(o_stall[0]), 5);
        cyc(I_B, B_B, 2'b00, 1'b1, 1'b1);
        check("t5_rst_stall", 32'(o_stall[0]), 0);
        check("t5_rst_block1", 32'(o_block[1]), 0);
        check("t5_rst_idx1",   32'(o_idx[1]),   0);
        cyc(I_B, B_B, 2'b00, 1'b0, 1'b0);
        check("t5_to1_block", 32'(o_block[1]), 1);
        check("t5_to1_idx",   32'(o_idx[1]),   3);
        check("t5_dut0_stall", 32'(o_stall[0]), 1);

        // Peak tracking across aborted episodes.
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(I_A, B_A, 2'b00, 1'b0, 1'b0);
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(I_A, B_A, 2'b00, 1'b0, 1'b0);
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b0);
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b0);
`ifdef DEADLOCK_MONITOR_PEAK_EN
        check("t6_peak", 32'(o_peak[0]), 5);
`endif
        cyc(ALL, NONE, 2'b00, 1'b1, 1'b0);
`ifdef DEADLOCK_MONITOR_PEAK_EN
        check("t6_peak_clr", 32'(o_peak[0]), 5);
`endif
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b1);
`ifdef DEADLOCK_MONITOR_PEAK_EN
        check("t6_peak_rst", 32'(o_peak[0]), 0);
`endif
        cyc(ALL, NONE, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/deadlock_monitor_param.md
Name: deadlock_monitor_param

Overview:
- Parametrised, synthesizable successor to the per-kernel deadlock monitor used by the HLS dataflow co-simulation harness.
- Watches N_INST dataflow process instances and N_AXIS top-level AXI-Stream ports.
- Declares a deadlock only after the "all stalled internally" condition holds for TIMEOUT consecutive cycles.
- On detection, latches a diagnostic snapshot: blocked-instance mask and first blocked index. The snapshot is held until cleared, so the testbench or a debug CSR can read it.

Parameters:
- N_INST, 6, number of monitored dataflow process instances.
- N_AXIS, 2, number of monitored top-level AXIS ports.
- TIMEOUT, 1024, consecutive candidate cycles required to declare deadlock (legal range 1..2**CNT_W-1).
- CNT_W, 16, width of the stall counter.
- IDX_W, $clog2(N_INST) (minimum 1), width of the instance index output.

Ports:
- kernel_monitor_clock, in, 1, sole clock; all state updates on its rising edge.
- kernel_monitor_reset, in, 1, synchronous active-high reset.
- axis_block_sigs, in, N_AXIS, bit i = AXIS port i is waiting on the testbench (external stall).
- inst_idle_sigs, in, N_INST, bit i = instance i has ap_idle asserted.
- inst_block_sigs, in, N_INST, bit i = instance i is blocked (waiting on ap_continue, or a FIFO blk_n is low).
- clear, in, 1, re-arms the monitor after a detection.
- block, out, 1, sticky deadlock flag.
- block_pulse, out, 1, single-cycle strobe in the cycle block first rises.
- blocked_mask, out, N_INST, inst_block_sigs captured at detection.
- first_blk_idx, out, IDX_W, lowest set bit of blocked_mask.
- stall_cycles, out, CNT_W, live stall counter.

Behaviour:
- Candidate condition, evaluated each cycle: cand = &(inst_idle_sigs | inst_block_sigs) & |inst_block_sigs & ~|axis_block_sigs.
  - Any AXIS stall is external, not a deadlock, so it forces cand=0.
  - All instances idle means the kernel is finished, so cand=0.
- Reset values: state=IDLE; block=0, block_pulse=0, blocked_mask=0, first_blk_idx=0, stall_cycles=0. Reset dominates clear and cand in the same cycle. Reset mid-WATCH or mid-DEADLOCK returns to IDLE with every output zeroed.
- FSM states IDLE, WATCH, DEADLOCK:
  - IDLE: cand=1 → WATCH, stall_cycles←1. Otherwise stay, stall_cycles←0.
  - WATCH, cand=0 → IDLE, stall_cycles←0.
  - WATCH, cand=1 and stall_cycles==TIMEOUT-1 → DEADLOCK. Same edge: block←1, block_pulse←1, blocked_mask←inst_block_sigs, first_blk_idx←prio_enc(inst_block_sigs), stall_cycles←TIMEOUT.
  - WATCH, otherwise → stall_cycles+1 (saturating at 2**CNT_W-1, never wraps).
  - DEADLOCK: holds outputs, ignores cand, stall_cycles frozen. clear=1 → IDLE with block=0, mask/idx/counter zeroed. clear in IDLE or WATCH has no effect.
- Latency:
  - block rises on the clock edge that ends the TIMEOUT-th consecutive cand cycle.
  - block_pulse is high exactly one cycle, registered alongside block.
- TIMEOUT=1: detection occurs on the first cand cycle. The IDLE→DEADLOCK transition is taken directly, with the same captures.
- Simultaneous cand drop and threshold: the cand value of that cycle decides, so no detection.
- N_INST=1: first_blk_idx is constant 0.

Optional Feature:
- Macro: DEADLOCK_MONITOR_PEAK_EN.
- Defined:
  - Adds output max_stall [CNT_W] holding the largest stall_cycles value reached since reset, including aborted WATCH episodes.
  - Updated the cycle after stall_cycles exceeds it.
  - Cleared by reset only, not by clear.
- Undefined: port and register absent. All other behaviour is identical.

Decomposition:
- Package deadlock_monitor_pkg: state enum (IDLE=2'd0, WATCH=2'd1, DEADLOCK=2'd2), function clog2_min1, default TIMEOUT constant.
- Sub-module dlm_prio_enc, parameters N/W: combinational lowest-set-bit encoder with a valid output. It is instantiated once, on inst_block_sigs.
- Everything else lives in deadlock_monitor_param.

Test Plan:
1. N_INST=6, TIMEOUT=8; idle=6'b111100, block=6'b000011, axis=0, held 8 cycles → block=1 and block_pulse=1 on the 8th edge; blocked_mask=6'b000011; first_blk_idx=0; stall_cycles=8.
2. Same stimulus as test 1, but axis_block_sigs=2'b01 asserted on cycle 5 → return to IDLE, stall_cycles=0, block never set. Releasing axis restarts counting from 1.
3. All idle (6'b111111), block=0 for 100 cycles → block stays 0 and stall_cycles stays 0 (kernel finished, not deadlock).
4. After detection, vary inputs for 20 cycles → outputs frozen. Pulse clear for 1 cycle → block=0, mask=0, state IDLE the next cycle; re-detection needs 8 new cand cycles.
5. Assert kernel_monitor_reset at WATCH cycle 5 together with clear=1 → all outputs 0 next cycle. TIMEOUT=1 variant: a single cand cycle sets block and first_blk_idx=3 for block=6'b101000.
6. With DEADLOCK_MONITOR_PEAK_EN: a 5-cycle aborted stall, then a 3-cycle one → max_stall=5. It survives clear and zeroes on reset.
